// File: rtl/decod2to4_seq.sv
// 2-to-4 one-hot decoder behind a 2-entry FIFO, with a saturating output-transfer counter.
// Latency: a code accepted into an empty FIFO is on D3..D0 the following cycle.
// Backpressure: in_ready drops only when both entries are full; out_ready is never passed through.
module decod2to4_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Y1,
  input  logic             Y0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             D0,
  output logic             D1,
  output logic             D2,
  output logic             D3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] dec_cnt
);

  logic [1:0]       code_mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       head_code;
  logic [3:0]       dec_dat;
  logic [CNT_W-1:0] cnt_max;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign head_code = code_mem[rd_ptr];
  assign cnt_max   = '1;

  // Storage needs no reset: pointers and occupancy alone decide what is visible.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      code_mem[wr_ptr] <= {Y1, Y0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
      dec_cnt <= '0;
    end else begin
      if (in_fire) begin
        wr_ptr <= ~wr_ptr;
      end
      if (out_fire) begin
        rd_ptr <= ~rd_ptr;
        if (dec_cnt != cnt_max) begin
          dec_cnt <= dec_cnt + 1'b1;
        end
      end
      case ({in_fire, out_fire})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_comb begin
    dec_dat = 4'b0000;
    if (out_valid) begin
      case (head_code)
        2'b00:   dec_dat = 4'b0001;
        2'b01:   dec_dat = 4'b0010;
        2'b10:   dec_dat = 4'b0100;
        default: dec_dat = 4'b1000;
      endcase
    end
  end

  assign {D3, D2, D1, D0} = dec_dat;

endmodule

// File: tb/tb_decod2to4_seq.sv
// Self-checking bench: directed vector table, a saturation sequence, then randomized traffic vs a queue model.
module tb_decod2to4_seq;

  logic       clk = 1'b0;
  logic       rst, Y1, Y0, in_valid, out_ready;
  logic       in_ready, D0, D1, D2, D3, out_valid;
  logic [7:0] dec_cnt;
  logic       in_ready_s, D0_s, D1_s, D2_s, D3_s, out_valid_s;
  logic [1:0] dec_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decod2to4_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .Y1(Y1), .Y0(Y0), .in_valid(in_valid), .in_ready(in_ready),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .out_valid(out_valid), .out_ready(out_ready),
    .dec_cnt(dec_cnt)
  );

  decod2to4_seq #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .Y1(Y1), .Y0(Y0), .in_valid(in_valid), .in_ready(in_ready_s),
    .D0(D0_s), .D1(D1_s), .D2(D2_s), .D3(D3_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .dec_cnt(dec_cnt_s)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [1:0] code;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [3:0] d;
    int         cnt;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Apply inputs, take one rising edge, and leave time for outputs to settle.
  task automatic step(input logic r, input logic iv, input logic [1:0] code, input logic ordy);
    rst = r; in_valid = iv; {Y1, Y0} = code; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic ir, input logic ov,
                           input logic [3:0] d, input int cnt);
    check({name, ".flags"}, {30'd0, in_ready, out_valid}, {30'd0, ir, ov});
    check({name, ".D"}, {28'd0, D3, D2, D1, D0}, {28'd0, d});
    check({name, ".cnt8"}, int'(dec_cnt), sat(cnt, 255));
    check({name, ".cnt2"}, int'(dec_cnt_s), sat(cnt, 3));
    check({name, ".small"}, {26'd0, in_ready_s, out_valid_s, D3_s, D2_s, D1_s, D0_s},
          {26'd0, ir, ov, d});
  endtask

  int         cnt_m;
  logic [1:0] q[$];
  logic       r_iv, r_ordy, r_rst, exp_ir, exp_ov;
  logic [1:0] r_code;
  logic [3:0] exp_d;
  int         ones;

  initial begin
    rst = 1'b1; in_valid = 1'b0; Y1 = 1'b0; Y0 = 1'b0; out_ready = 1'b0;

    //          rst   iv    code   ordy  ir    ov    D        cnt
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 0};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001, 0};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0010, 1};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0100, 2};
    tbl[4]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000, 3};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4};
    tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0100, 4};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'b0100, 4};
    tbl[8]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100, 4};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'b0100, 4};
    tbl[10] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 4'b0010, 5};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 6};
    tbl[12] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 6};
    tbl[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0001, 6};
    tbl[14] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000, 7};
    tbl[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'b1000, 7};
    tbl[16] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 0};
    tbl[17] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 4'b0010, 0};
    tbl[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 0};

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].code, tbl[i].ordy);
      check_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].d, tbl[i].cnt);
    end

    // Counter saturation: one push, then five back-to-back output transfers.
    step(1'b0, 1'b1, 2'd2, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 2'd2, 1'b1);
      check($sformatf("sat%0d.cnt2", k), int'(dec_cnt_s), sat(k, 3));
      check($sformatf("sat%0d.cnt8", k), int'(dec_cnt), k);
    end

    // Randomized traffic against a queue model of the FIFO.
    step(1'b1, 1'b0, 2'd0, 1'b0);
    q.delete();
    cnt_m = 0;
    for (int c = 0; c < 1000; c++) begin
      r_rst  = ($urandom_range(63) == 0);
      r_iv   = $urandom_range(1);
      r_ordy = $urandom_range(1);
      r_code = 2'($urandom_range(3));
      exp_ir = (q.size() < 2);
      exp_ov = (q.size() > 0);
      if (r_rst) begin
        q.delete();
        cnt_m = 0;
      end else begin
        if (exp_ov && r_ordy) begin
          void'(q.pop_front());
          cnt_m++;
        end
        if (r_iv && exp_ir) q.push_back(r_code);
      end
      step(r_rst, r_iv, r_code, r_ordy);
      exp_ir = (q.size() < 2);
      exp_ov = (q.size() > 0);
      exp_d  = exp_ov ? (4'b0001 << q[0]) : 4'b0000;
      ones   = $countones({D3, D2, D1, D0});
      check($sformatf("rnd%0d.onehot", c), int'(ones <= 1), 1);
      check_all($sformatf("rnd%0d", c), exp_ir, exp_ov, exp_d, cnt_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decod2to4_seq.md
DECOD2TO4_SEQ -- requirements
Module: decod2to4_seq

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the transfer counter dec_cnt.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Y1  input  1  SHALL be the code MSB.
REQ-005 Y0  input  1  SHALL be the code LSB.
REQ-006 in_valid  input  1  SHALL mark {Y1,Y0} as valid this cycle.
REQ-007 in_ready  output  1  SHALL indicate the block can accept a code this cycle.
REQ-008 D0  output  1  SHALL be the one-hot line for code 00.
REQ-009 D1  output  1  SHALL be the one-hot line for code 01.
REQ-010 D2  output  1  SHALL be the one-hot line for code 10.
REQ-011 D3  output  1  SHALL be the one-hot line for code 11.
REQ-012 out_valid  output  1  SHALL indicate D3..D0 hold a valid decoded word.
REQ-013 out_ready  input  1  SHALL indicate the consumer takes the current word this cycle.
REQ-014 dec_cnt  output  CNT_W  SHALL be the count of completed output transfers.

Function
REQ-015 Input transfer SHALL occur on a rising edge where in_valid && in_ready; output transfer SHALL occur where out_valid && out_ready.
REQ-016 Codes SHALL be held in a 2-entry FIFO (occupancy 0, 1 or 2), delivered in acceptance order, none dropped or duplicated.
REQ-017 in_ready SHALL be 1 when occupancy < 2 and 0 when occupancy = 2, independent of out_ready (no pass-through when full).
REQ-018 out_valid SHALL be 1 exactly when occupancy > 0.
REQ-019 When out_valid=1, exactly one of D3..D0 SHALL be 1, selected by the head code: 00->D0, 01->D1, 10->D2, 11->D3.
REQ-020 When out_valid=0, D3..D0 SHALL all be 0.
REQ-021 Latency: a code accepted into an empty FIFO SHALL appear on D3..D0 with out_valid=1 in the cycle after acceptance.
REQ-022 D3..D0 and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous input and output transfer SHALL leave occupancy unchanged; at occupancy 1 the new code becomes head the next cycle.
REQ-024 Input transfer alone SHALL increment occupancy; output transfer alone SHALL decrement it.
REQ-025 out_ready with out_valid=0 SHALL have no effect; in_valid with in_ready=0 SHALL be ignored and {Y1,Y0} not captured.
REQ-026 dec_cnt SHALL increment by 1 on each output transfer and saturate at 2^CNT_W-1 (no wrap).
REQ-027 Y1/Y0 SHALL be ignored whenever no input transfer occurs.

Reset
REQ-028 While rst=1 at a clock edge, occupancy SHALL become 0, out_valid=0, D3..D0=0000, in_ready=1, dec_cnt=0.
REQ-029 rst SHALL take priority over any simultaneous input or output transfer; FIFO contents are discarded.
REQ-030 In the first cycle after rst is released, the block SHALL accept input normally.

Verification
REQ-031 Reset, then in_valid=1 with {Y1,Y0}=00,01,10,11 on successive cycles, out_ready=1 -> D3..D0 = 0001,0010,0100,1000 in order, each one cycle after acceptance; dec_cnt=4.
REQ-032 out_ready=0, push 10 then 01 -> in_ready=0 after second push; third push (11) ignored; D3..D0 holds 0100; then out_ready=1 -> 0100, 0010, then out_valid=0, D=0000.
REQ-033 Occupancy 1 (head 00), in_valid=1 code 11 and out_ready=1 same cycle -> next cycle D3..D0=1000, out_valid=1, occupancy 1.
REQ-034 CNT_W=2, perform 5 output transfers -> dec_cnt reads 1,2,3,3,3.
REQ-035 Occupancy 2, assert rst with in_valid=1 and out_ready=1 -> next cycle out_valid=0, D=0000, in_ready=1, dec_cnt=0.
REQ-036 Randomized in_valid/out_ready for 1000 cycles -> output sequence equals accepted sequence decoded, D always one-hot or zero, never two lines high.
